// File: rtl/bin_to_dec_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_dec_pkg
//   Shared types and constants for the decimal conversion/decode blocks.
//   - state_e    : conversion FSM states (IDLE, SHIFT, DONE)
//   - DIGIT_W    : bits per BCD digit
//   - ONEHOT_W   : lines per decoded decimal digit
//   - min_digits : decimal digits needed to hold any WIDTH-bit unsigned value
// -----------------------------------------------------------------------------
package bin_to_dec_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DIGIT_W  = 4;
   localparam int ONEHOT_W = 10;

   // Digit count of 2**width - 1, i.e. floor(width * log10(2)) + 1.
   // 30103/100000 approximates log10(2) closely enough for any practical width.
   function automatic int min_digits(input int width);
      return (width * 30103) / 100000 + 1;
   endfunction

endpackage

// File: rtl/dec_digit_onehot.sv
// -----------------------------------------------------------------------------
// dec_digit_onehot
//   Decodes one BCD digit into a 10-line one-hot decimal field.
//   Codes 10..15 are not decimal digits and produce an all-zero field.
//   Ports:
//     bcd_i    in  4   BCD digit
//     onehot_o out 10  bit k set iff bcd_i == k
// -----------------------------------------------------------------------------
module dec_digit_onehot
   import bin_to_dec_pkg::*;
(
   input  logic [DIGIT_W-1:0]  bcd_i,
   output logic [ONEHOT_W-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int k = 0; k < ONEHOT_W; k++) begin
         onehot_o[k] = (bcd_i == DIGIT_W'(k));
      end
   end

endmodule

// File: rtl/bin_to_dec_seq_decoder.sv
// -----------------------------------------------------------------------------
// bin_to_dec_seq_decoder
//   Sequential binary-to-decimal converter (double dabble, one bit per cycle)
//   with a per-digit one-hot decimal decode, blanking and overflow flag.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1. in_ready is 1 only in IDLE (and never while rst is high); out_valid
//   is 1 only in DONE, and the result is held stable until out_ready is seen.
//
//   Ports:
//     clk         in   1            rising-edge clock
//     rst         in   1            synchronous active-high reset
//     in_valid    in   1            in_bin is valid
//     in_ready    out  1            block accepts a new word
//     in_bin      in   WIDTH        unsigned binary operand
//     blank       in   1            1 = out_onehot forced to zero
//     out_valid   out  1            result is valid
//     out_ready   in   1            consumer accepts the result
//     out_bcd     out  4*DIGITS     BCD result, digit 0 least significant
//     out_onehot  out  10*DIGITS    one-hot decimal field per digit
//     overflow    out  1            in_bin >= 10**DIGITS
//     dbg_state_o out  2            current FSM state
// -----------------------------------------------------------------------------
module bin_to_dec_seq_decoder
   import bin_to_dec_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_bin,
   input  logic                         blank,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DIGIT_W*DIGITS-1:0]    out_bcd,
   output logic [ONEHOT_W*DIGITS-1:0]   out_onehot,
   output logic                         overflow,
   output state_e                       dbg_state_o
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     bin_q, bin_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic                 ovf_q, ovf_d;
   logic [BCD_W-1:0]     out_bcd_q, out_bcd_d;
   logic                 out_ovf_q, out_ovf_d;
   // Set once a result has been published since reset; keeps the display
   // dark until then even though out_bcd=0 would decode to "0" in every field.
   logic                 has_q, has_d;

   logic [BCD_W-1:0]     bcd_adj;
   logic [BCD_W-1:0]     bcd_sh;
   logic [WIDTH-1:0]     bin_sh;
   logic                 shift_carry;
   logic [ONEHOT_W*DIGITS-1:0] onehot_raw;

   // One double-dabble step: correct digits >= 5, then shift {bcd,bin} left.
   // A bit leaving the top digit means the value reached 10**DIGITS.
   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_q[DIGIT_W*d +: DIGIT_W] >= 4'd5) begin
            bcd_adj[DIGIT_W*d +: DIGIT_W] = bcd_q[DIGIT_W*d +: DIGIT_W] + 4'd3;
         end
      end
      shift_carry = bcd_adj[BCD_W-1];
      bcd_sh      = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
      bin_sh      = bin_q << 1;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      out_bcd_d = out_bcd_q;
      out_ovf_d = out_ovf_q;
      has_d     = has_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               bin_d   = in_bin;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bin_d = bin_sh;
            bcd_d = bcd_sh;
            ovf_d = ovf_q | shift_carry;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d   = DONE;
               out_bcd_d = bcd_sh;
               out_ovf_d = ovf_q | shift_carry;
               has_d     = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bin_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         out_bcd_q <= '0;
         out_ovf_q <= 1'b0;
         has_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         out_bcd_q <= out_bcd_d;
         out_ovf_q <= out_ovf_d;
         has_q     <= has_d;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      dec_digit_onehot u_dec (
         .bcd_i    (out_bcd_q[DIGIT_W*g +: DIGIT_W]),
         .onehot_o (onehot_raw[ONEHOT_W*g +: ONEHOT_W])
      );
   end

   assign in_ready    = (state_q == IDLE) && !rst;
   assign out_valid   = (state_q == DONE);
   assign out_bcd     = out_bcd_q;
   assign overflow    = out_ovf_q;
   assign out_onehot  = (blank || !has_q) ? '0 : onehot_raw;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bin_to_dec_seq_decoder.sv
module tb_bin_to_dec_seq_decoder;
   import bin_to_dec_pkg::*;

   localparam int W  = 8;
   localparam int D1 = 3;
   localparam int D2 = 2;

   // ---------------- clock / reset / signals ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic [W-1:0] in_bin = '0;
   logic blank = 1'b0;
   logic out_ready = 1'b1;

   logic in_ready, out_valid, overflow;
   logic [4*D1-1:0]  out_bcd;
   logic [10*D1-1:0] out_onehot;
   state_e dbg_state;

   logic in_ready2, out_valid2, overflow2;
   logic [4*D2-1:0]  out_bcd2;
   logic [10*D2-1:0] out_onehot2;
   state_e dbg_state2;

   int n_cmp = 0;
   int n_fail = 0;

   logic [4*D1:0] exp1_q[$];
   logic [4*D2:0] exp2_q[$];

   always #5 clk = ~clk;

   bin_to_dec_seq_decoder #(.WIDTH(W), .DIGITS(D1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_bin(in_bin), .blank(blank), .out_valid(out_valid),
      .out_ready(out_ready), .out_bcd(out_bcd), .out_onehot(out_onehot),
      .overflow(overflow), .dbg_state_o(dbg_state)
   );

   bin_to_dec_seq_decoder #(.WIDTH(W), .DIGITS(D2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_bin(in_bin), .blank(blank), .out_valid(out_valid2),
      .out_ready(out_ready), .out_bcd(out_bcd2), .out_onehot(out_onehot2),
      .overflow(overflow2), .dbg_state_o(dbg_state2)
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_bcd(input int v, input int nd);
      logic [31:0] r;
      int x;
      r = '0;
      x = v;
      for (int d = 0; d < nd; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic model_ovf(input int v, input int nd);
      int p;
      p = 1;
      for (int d = 0; d < nd; d++) p = p * 10;
      return v >= p;
   endfunction

   function automatic logic [63:0] model_onehot(input logic [31:0] bcd, input int nd,
                                                input logic blk);
      logic [63:0] r;
      r = '0;
      if (!blk) begin
         for (int d = 0; d < nd; d++) r[10*d + int'(bcd[4*d +: 4])] = 1'b1;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      logic [4*D1:0] e;
      if (!rst && out_valid && out_ready) begin
         check("d3_pending", 64'(exp1_q.size() != 0), 64'd1);
         if (exp1_q.size() != 0) begin
            e = exp1_q.pop_front();
            check("d3_bcd", 64'(out_bcd), 64'(e[4*D1-1:0]));
            check("d3_ovf", 64'(overflow), 64'(e[4*D1]));
            check("d3_onehot", 64'(out_onehot), model_onehot(32'(e[4*D1-1:0]), D1, blank));
            if (!blank) begin
               for (int d = 0; d < D1; d++)
                  check("d3_field_onehot", 64'($onehot(out_onehot[10*d +: 10])), 64'd1);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [4*D2:0] e;
      if (!rst && out_valid2 && out_ready) begin
         check("d2_pending", 64'(exp2_q.size() != 0), 64'd1);
         if (exp2_q.size() != 0) begin
            e = exp2_q.pop_front();
            check("d2_bcd", 64'(out_bcd2), 64'(e[4*D2-1:0]));
            check("d2_ovf", 64'(overflow2), 64'(e[4*D2]));
            check("d2_onehot", 64'(out_onehot2), model_onehot(32'(e[4*D2-1:0]), D2, blank));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_exp(input int v);
      exp1_q.push_back({model_ovf(v, D1), 12'(model_bcd(v, D1))});
      exp2_q.push_back({model_ovf(v, D2), 8'(model_bcd(v, D2))});
   endtask

   task automatic wait_in_ready();
      int t = 0;
      while (!(in_ready && in_ready2) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("in_ready_wait", 64'(in_ready && in_ready2), 64'd1);
   endtask

   task automatic send(input int v);
      wait_in_ready();
      in_valid = 1'b1;
      in_bin   = W'(v);
      push_exp(v);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Edges counted from the cycle in_valid is presented to out_valid seen.
   task automatic send_timed(input int v, output int lat);
      wait_in_ready();
      in_valid = 1'b1;
      in_bin   = W'(v);
      push_exp(v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic wait_out_valid(input string name);
      int t = 0;
      while (!out_valid && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check(name, 64'(out_valid), 64'd1);
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp1_q.size() != 0 || exp2_q.size() != 0) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", 64'(exp1_q.size() + exp2_q.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int cnt;
      int order[256];

      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_bcd", 64'(out_bcd), 64'd0);
      check("rst_onehot", 64'(out_onehot), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      rst = 1'b0;
      #1;
      check("rst_release_in_ready", 64'(in_ready), 64'd1);

      // zero input and latency
      out_ready = 1'b1;
      send_timed(0, lat);
      check("t1_latency", 64'(lat), 64'(W + 1));
      check("t1_bcd", 64'(out_bcd), 64'h000);
      check("t1_onehot", 64'(out_onehot), 64'h0010_0401);
      check("t1_ovf", 64'(overflow), 64'd0);
      wait_drain();

      // max input and latency
      send_timed(255, lat);
      check("t2_latency", 64'(lat), 64'(W + 1));
      check("t2_bcd", 64'(out_bcd), 64'h255);
      check("t2_onehot", 64'(out_onehot), 64'h0040_8020);
      check("t2_ovf", 64'(overflow), 64'd0);
      wait_drain();

      // back-pressure: result held, in_valid ignored in DONE
      out_ready = 1'b0;
      send(9);
      wait_out_valid("t3_valid");
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", 64'(out_valid), 64'd1);
         check("t3_hold_bcd", 64'(out_bcd), 64'h009);
         check("t3_in_ready", 64'(in_ready), 64'd0);
         if (i == 2) begin
            in_valid = 1'b1;
            in_bin   = 8'd77;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      check("t3_state_done", 64'(dbg_state), 64'(DONE));
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_state_idle", 64'(dbg_state), 64'(IDLE));
      check("t3_in_ready_after", 64'(in_ready), 64'd1);
      check("t3_q_empty", 64'(exp1_q.size()), 64'd0);
      send(123);
      wait_drain();

      // blanking in DONE
      out_ready = 1'b0;
      send(137);
      wait_out_valid("t4_valid");
      blank = 1'b1;
      #1;
      check("t4_blank_onehot", 64'(out_onehot), 64'd0);
      check("t4_blank_bcd", 64'(out_bcd), 64'h137);
      blank = 1'b0;
      #1;
      check("t4_onehot", 64'(out_onehot), 64'h0020_2080);
      out_ready = 1'b1;
      wait_drain();

      // two-digit instance overflow
      out_ready = 1'b0;
      send(199);
      wait_out_valid("t5_valid");
      check("t5_bcd2", 64'(out_bcd2), 64'h99);
      check("t5_ovf2", 64'(overflow2), 64'd1);
      out_ready = 1'b1;
      wait_drain();
      out_ready = 1'b0;
      send(99);
      wait_out_valid("t5b_valid");
      check("t5b_bcd2", 64'(out_bcd2), 64'h99);
      check("t5b_ovf2", 64'(overflow2), 64'd0);
      out_ready = 1'b1;
      wait_drain();

      // reset during SHIFT aborts the conversion
      wait_in_ready();
      in_valid = 1'b1;
      in_bin   = 8'd200;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("t6_rst_in_ready", 64'(in_ready), 64'd0);
      check("t6_rst_valid", 64'(out_valid), 64'd0);
      check("t6_rst_bcd", 64'(out_bcd), 64'd0);
      check("t6_rst_onehot", 64'(out_onehot), 64'd0);
      check("t6_rst_ovf", 64'(overflow), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("t6_in_ready_after", 64'(in_ready), 64'd1);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      check("t6_no_valid", 64'(cnt), 64'd0);
      send(42);
      wait_drain();

      // randomized sweep over all inputs
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j;
         int tmp;
         j = $urandom_range(0, i);
         tmp = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         out_ready = 1'b0;
         blank = 1'($urandom_range(0, 1));
         send(order[i]);
         wait_out_valid("sweep_valid");
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         blank = 1'($urandom_range(0, 1));
         out_ready = 1'b1;
         wait_drain();
      end
      blank = 1'b0;

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
